pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage pipelined CPU, replacing the fixed-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries a valid bit, a control bundle and a data bundle. It supports hazard-unit stall (hold) and branch/jump flush (bubble insertion), and keeps saturating stall and bubble counters for performance measurement.

---
 rtl/cpu_pipe_pkg.sv | 45 ++++
 rtl/pipe_stage_reg_if.sv | 29 ++
 rtl/pipe_sat_ctr.sv | 22 ++
 rtl/pipe_stage_reg.sv | 81 ++++++++
 tb/tb_pipe_stage_reg.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the pipelined CPU's inter-stage registers: default
// bundle widths per stage boundary, control-field bit positions and the stage action decode.
package cpu_pipe_pkg;

    localparam int unsigned DEF_CTRL_W = 8;
    localparam int unsigned DEF_DATA_W = 133;

    // Bundle widths at each stage boundary (data: pc4/a/b/imm/rn style packing)
    localparam int unsigned IF_ID_CTRL_W  = 1;
    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned ID_EX_CTRL_W  = 10;
    localparam int unsigned ID_EX_DATA_W  = 133;
    localparam int unsigned EX_MEM_CTRL_W = 3;
    localparam int unsigned EX_MEM_DATA_W = 69;
    localparam int unsigned MEM_WB_CTRL_W = 2;
    localparam int unsigned MEM_WB_DATA_W = 69;

    // Control-field positions; later stages keep a prefix of the ID/EX bundle
    localparam int unsigned CTRL_WREG     = 0;
    localparam int unsigned CTRL_M2REG    = 1;
    localparam int unsigned CTRL_WMEM     = 2;
    localparam int unsigned CTRL_ALUIMM   = 3;
    localparam int unsigned CTRL_SHIFT    = 4;
    localparam int unsigned CTRL_JAL      = 5;
    localparam int unsigned CTRL_ALUC_LSB = 6;
    localparam int unsigned CTRL_ALUC_MSB = 9;

    typedef enum logic [1:0] {
        ActLoad  = 2'd0,
        ActHold  = 2'd1,
        ActFlush = 2'd2
    } stage_act_e;

    // Flush outranks stall
    function automatic stage_act_e stage_act(input logic stall, input logic flush);
        if (flush) begin
            return ActFlush;
        end
        if (stall) begin
            return ActHold;
        end
        return ActLoad;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream bundle of one pipeline stage register, plus the hazard-unit
// stall/flush controls that steer it.
interface pipe_stage_reg_if
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic              stall;
    logic              flush;
    logic              d_valid;
    logic [CTRL_W-1:0] d_ctrl;
    logic [DATA_W-1:0] d_data;
    logic              e_valid;
    logic [CTRL_W-1:0] e_ctrl;
    logic [DATA_W-1:0] e_data;

    modport master (
        output stall, flush, d_valid, d_ctrl, d_data,
        input  e_valid, e_ctrl, e_data
    );

    modport slave (
        input  stall, flush, d_valid, d_ctrl, d_data,
        output e_valid, e_ctrl, e_data
    );

endinterface

// File: rtl/pipe_sat_ctr.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_ctr #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register with stall (hold), flush (bubble) and
// saturating stall/bubble performance counters.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned CTRL_W     = DEF_CTRL_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned CNT_W      = 16,
    parameter bit          CLEAR_DATA = 1'b0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             cnt_clr,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    stage_act_e        act;
    logic              e_valid_q;
    logic [CTRL_W-1:0] e_ctrl_q;
    logic [DATA_W-1:0] e_data_q;
    logic              stall_inc;
    logic              bubble_inc;

    assign act = stage_act(bus.stall, bus.flush);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            e_valid_q <= 1'b0;
            e_ctrl_q  <= '0;
            e_data_q  <= '0;
        end else begin
            case (act)
                ActFlush: begin
                    e_valid_q <= 1'b0;
                    e_ctrl_q  <= '0;
                    if (CLEAR_DATA) begin
                        e_data_q <= '0;
                    end
                end
                ActHold: begin
                end
                default: begin
                    e_valid_q <= bus.d_valid;
                    // Gate control so an invalid slot can never write RF or memory
                    e_ctrl_q  <= bus.d_valid ? bus.d_ctrl : '0;
                    e_data_q  <= bus.d_data;
                end
            endcase
        end
    end

    assign bus.e_valid = e_valid_q;
    assign bus.e_ctrl  = e_ctrl_q;
    assign bus.e_data  = e_data_q;

    assign stall_inc  = (act == ActHold);
    assign bubble_inc = (act == ActFlush) || ((act == ActLoad) && !bus.d_valid);

    pipe_sat_ctr #(
        .CNT_W (CNT_W)
    ) u_stall_ctr (
        .clock  (clock),
        .resetn (resetn),
        .clr    (cnt_clr),
        .inc    (stall_inc),
        .count  (stall_cnt)
    );

    pipe_sat_ctr #(
        .CNT_W (CNT_W)
    ) u_bubble_ctr (
        .clock  (clock),
        .resetn (resetn),
        .clr    (cnt_clr),
        .inc    (bubble_inc),
        .count  (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two builds (hold-data/4-bit counters, clear-data/16-bit
// counters) driven in lockstep, checked by directed vectors and a reference model.
module tb_pipe_stage_reg;

    logic        clock;
    logic        resetn;
    logic        cnt_clr;
    logic        stall;
    logic        flush;
    logic        d_valid;
    logic [7:0]  d_ctrl;
    logic [31:0] d_data;
    logic [3:0]  stall_cnt_a;
    logic [3:0]  bubble_cnt_a;
    logic [15:0] stall_cnt_b;
    logic [15:0] bubble_cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(32)) bus_a ();
    pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(32)) bus_b ();

    assign bus_a.stall   = stall;
    assign bus_a.flush   = flush;
    assign bus_a.d_valid = d_valid;
    assign bus_a.d_ctrl  = d_ctrl;
    assign bus_a.d_data  = d_data;
    assign bus_b.stall   = stall;
    assign bus_b.flush   = flush;
    assign bus_b.d_valid = d_valid;
    assign bus_b.d_ctrl  = d_ctrl;
    assign bus_b.d_data  = d_data;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .CNT_W(4), .CLEAR_DATA(1'b0)) dut_a (
        .clock      (clock),
        .resetn     (resetn),
        .cnt_clr    (cnt_clr),
        .bus        (bus_a),
        .stall_cnt  (stall_cnt_a),
        .bubble_cnt (bubble_cnt_a)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .CNT_W(16), .CLEAR_DATA(1'b1)) dut_b (
        .clock      (clock),
        .resetn     (resetn),
        .cnt_clr    (cnt_clr),
        .bus        (bus_b),
        .stall_cnt  (stall_cnt_b),
        .bubble_cnt (bubble_cnt_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: index 0 = hold-data build (cap 15), 1 = clear-data build (cap 65535)
    logic        m_valid [2];
    logic [7:0]  m_ctrl  [2];
    logic [31:0] m_data  [2];
    int          m_sc    [2];
    int          m_bc    [2];
    int          cap     [2] = '{15, 65535};

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int k);
        return (v < cap[k]) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_ctrl[k]  = '0;
            m_data[k]  = '0;
            m_sc[k]    = 0;
            m_bc[k]    = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                m_valid[k] = 1'b0;
                m_ctrl[k]  = '0;
                m_data[k]  = '0;
                m_sc[k]    = 0;
                m_bc[k]    = 0;
            end else begin
                if (flush) begin
                    m_valid[k] = 1'b0;
                    m_ctrl[k]  = '0;
                    if (k == 1) m_data[k] = '0;
                    m_bc[k] = sat_inc(m_bc[k], k);
                end else if (stall) begin
                    m_sc[k] = sat_inc(m_sc[k], k);
                end else begin
                    m_valid[k] = d_valid;
                    m_ctrl[k]  = d_valid ? d_ctrl : 8'h00;
                    m_data[k]  = d_data;
                    if (!d_valid) m_bc[k] = sat_inc(m_bc[k], k);
                end
                if (cnt_clr) begin
                    m_sc[k] = 0;
                    m_bc[k] = 0;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".a.valid"},  32'(bus_a.e_valid), 32'(m_valid[0]));
        cmp({tag, ".a.ctrl"},   32'(bus_a.e_ctrl),  32'(m_ctrl[0]));
        cmp({tag, ".a.data"},   bus_a.e_data,       m_data[0]);
        cmp({tag, ".a.stall"},  32'(stall_cnt_a),   32'(m_sc[0]));
        cmp({tag, ".a.bubble"}, 32'(bubble_cnt_a),  32'(m_bc[0]));
        cmp({tag, ".b.valid"},  32'(bus_b.e_valid), 32'(m_valid[1]));
        cmp({tag, ".b.ctrl"},   32'(bus_b.e_ctrl),  32'(m_ctrl[1]));
        cmp({tag, ".b.data"},   bus_b.e_data,       m_data[1]);
        cmp({tag, ".b.stall"},  32'(stall_cnt_b),   32'(m_sc[1]));
        cmp({tag, ".b.bubble"}, 32'(bubble_cnt_b),  32'(m_bc[1]));
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, ".a.valid"},  32'(bus_a.e_valid), 32'd0);
        cmp({tag, ".a.ctrl"},   32'(bus_a.e_ctrl),  32'd0);
        cmp({tag, ".a.data"},   bus_a.e_data,       32'd0);
        cmp({tag, ".a.cnts"},   32'({stall_cnt_a, bubble_cnt_a}), 32'd0);
        cmp({tag, ".b.data"},   bus_b.e_data,       32'd0);
        cmp({tag, ".b.cnts"},   {stall_cnt_b, bubble_cnt_b}, 32'd0);
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic        cnt_clr;
        logic        d_valid;
        logic [7:0]  d_ctrl;
        logic [31:0] d_data;
        logic        e_valid;
        logic [7:0]  e_ctrl;
        logic [31:0] e_data_a;
        logic [31:0] e_data_b;
        int          sc;
        int          bc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic f, input logic c, input logic v,
                                input logic [7:0] dc, input logic [31:0] dd, input logic ev,
                                input logic [7:0] ec, input logic [31:0] eda,
                                input logic [31:0] edb, input int sc, input int bc);
        vec_t r;
        r.stall = s; r.flush = f; r.cnt_clr = c; r.d_valid = v; r.d_ctrl = dc; r.d_data = dd;
        r.e_valid = ev; r.e_ctrl = ec; r.e_data_a = eda; r.e_data_b = edb; r.sc = sc; r.bc = bc;
        return r;
    endfunction

    vec_t vecs [11];

    initial begin
        //           stl  fl  clr  dv   dctrl  d_data         ev   ectrl  e_data_a      e_data_b   sc bc
        vecs[0]  = mk(0, 0, 0, 1, 8'hA5, 32'h0040_0004, 1, 8'hA5, 32'h0040_0004, 32'h0040_0004, 0, 0);
        vecs[1]  = mk(1, 0, 0, 1, 8'h3C, 32'hDEAD_BEEF, 1, 8'hA5, 32'h0040_0004, 32'h0040_0004, 1, 0);
        vecs[2]  = mk(1, 0, 0, 1, 8'h3C, 32'hDEAD_BEEF, 1, 8'hA5, 32'h0040_0004, 32'h0040_0004, 2, 0);
        vecs[3]  = mk(1, 0, 0, 1, 8'h3C, 32'hDEAD_BEEF, 1, 8'hA5, 32'h0040_0004, 32'h0040_0004, 3, 0);
        vecs[4]  = mk(0, 0, 0, 1, 8'h3C, 32'hDEAD_BEEF, 1, 8'h3C, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, 0);
        vecs[5]  = mk(1, 1, 0, 1, 8'h77, 32'h1111_1111, 0, 8'h00, 32'hDEAD_BEEF, 32'h0000_0000, 3, 1);
        vecs[6]  = mk(0, 0, 0, 0, 8'hFF, 32'h1234_5678, 0, 8'h00, 32'h1234_5678, 32'h1234_5678, 3, 2);
        vecs[7]  = mk(0, 1, 0, 1, 8'h42, 32'h5555_AAAA, 0, 8'h00, 32'h1234_5678, 32'h0000_0000, 3, 3);
        vecs[8]  = mk(0, 0, 1, 1, 8'h81, 32'hCAFE_F00D, 1, 8'h81, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0);
        vecs[9]  = mk(1, 0, 1, 0, 8'h00, 32'h0000_0001, 1, 8'h81, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0);
        vecs[10] = mk(1, 0, 0, 0, 8'h00, 32'h0000_0002, 1, 8'h81, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0);

        resetn = 1'b0; cnt_clr = 1'b0; stall = 1'b0; flush = 1'b0;
        d_valid = 1'b0; d_ctrl = '0; d_data = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_zero("rst_hold");
        resetn = 1'b1;

        // Load something nonzero, then drop reset mid-cycle
        d_valid = 1'b1; d_ctrl = 8'h5A; d_data = 32'hFFFF_FFFF; stall = 1'b0;
        tick("preload");
        #3;
        resetn = 1'b0;
        #1;
        model_reset();
        check_zero("async_rst");
        tick("rst_low_edge");
        resetn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            stall = vecs[i].stall; flush = vecs[i].flush; cnt_clr = vecs[i].cnt_clr;
            d_valid = vecs[i].d_valid; d_ctrl = vecs[i].d_ctrl; d_data = vecs[i].d_data;
            tick($sformatf("vec%0d", i));
            cmp($sformatf("vec%0d.e_valid", i), 32'(bus_a.e_valid), 32'(vecs[i].e_valid));
            cmp($sformatf("vec%0d.e_ctrl", i), 32'(bus_a.e_ctrl), 32'(vecs[i].e_ctrl));
            cmp($sformatf("vec%0d.e_data_a", i), bus_a.e_data, vecs[i].e_data_a);
            cmp($sformatf("vec%0d.e_data_b", i), bus_b.e_data, vecs[i].e_data_b);
            cmp($sformatf("vec%0d.stall_cnt", i), 32'(stall_cnt_a), 32'(vecs[i].sc));
            cmp($sformatf("vec%0d.bubble_cnt", i), 32'(bubble_cnt_a), 32'(vecs[i].bc));
        end
        cnt_clr = 1'b0;

        // Saturation: 4-bit counter pins at 15, the 16-bit one keeps counting
        stall = 1'b1;
        for (int i = 0; i < 20; i++) tick("sat");
        cmp("sat.a_stall_cnt", 32'(stall_cnt_a), 32'd15);
        cmp("sat.b_stall_cnt", 32'(stall_cnt_b), 32'd21);
        cnt_clr = 1'b1;
        tick("clr_with_stall");
        cmp("clr.a_stall_cnt", 32'(stall_cnt_a), 32'd0);
        cmp("clr.b_stall_cnt", 32'(stall_cnt_b), 32'd0);
        cnt_clr = 1'b0;
        tick("after_clr");
        cmp("after_clr.a_stall_cnt", 32'(stall_cnt_a), 32'd1);
        cmp("after_clr.b_stall_cnt", 32'(stall_cnt_b), 32'd1);

        // Randomized traffic against the model, with one asynchronous reset thrown in
        for (int i = 0; i < 400; i++) begin
            stall   = ($urandom_range(0, 99) < 25);
            flush   = ($urandom_range(0, 99) < 15);
            cnt_clr = ($urandom_range(0, 99) < 2);
            d_valid = ($urandom_range(0, 99) < 60);
            d_ctrl  = 8'($urandom);
            d_data  = $urandom;
            tick("rand");
            if (i == 200) begin
                #2;
                resetn = 1'b0;
                #1;
                model_reset();
                check_model("rand_rst");
                resetn = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
